// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-TX state encoding, command bytes, default timing.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RTS,
    XFER,
    ACK,
    WAIT_IDLE
  } tx_state_e;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_ECHO    = 8'hEE;
  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] RSP_ACK     = 8'hFA;

  // 100 us inhibit, 15 ms device timeout at 50 MHz
  localparam int INHIBIT_CYCLES_DEF = 5000;
  localparam int TIMEOUT_CYCLES_DEF = 750000;
  localparam int FILTER_LEN_DEF     = 8;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// Synchronizes both PS/2 lines and debounces the clock; fall_o pulses once per
// accepted 1->0 clock transition. Shared with the keyboard receiver.
module ps2_clk_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = FILTER_LEN_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2c_i,
  input  logic ps2d_i,
  output logic ps2c_sync_o,
  output logic ps2d_sync_o,
  output logic fall_o
);
  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    c_sync_q, d_sync_q;
  logic          filt_q, fall_q;
  logic [CW-1:0] cnt_q;

  // Sync and filter flops reset to the idle-high bus level so no spurious edge
  // is seen when reset is released.
  always_ff @(posedge clk) begin
    if (reset) begin
      c_sync_q <= 2'b11;
      d_sync_q <= 2'b11;
      filt_q   <= 1'b1;
      fall_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      c_sync_q <= {c_sync_q[0], ps2c_i};
      d_sync_q <= {d_sync_q[0], ps2d_i};
      fall_q   <= 1'b0;
      if (c_sync_q[1] == filt_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
        filt_q <= c_sync_q[1];
        fall_q <= filt_q;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign ps2c_sync_o = c_sync_q[1];
  assign ps2d_sync_o = d_sync_q[1];
  assign fall_o      = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, 11-bit frame clocked by the
// device, ack check and timeout abort. Lines are driven only via pull-low enables.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = INHIBIT_CYCLES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int FILTER_LEN     = FILTER_LEN_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr,
  input  logic [7:0] din,
  input  logic       ps2c_in,
  input  logic       ps2d_in,
  output logic       ps2c_oe,
  output logic       ps2d_oe,
  output logic       busy,
  output logic       done_tick,
  output logic       err
);
  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  tx_state_e     state_q, state_d;
  logic [7:0]    data_q, data_d;
  logic          par_q, par_d;
  logic          c_oe_q, c_oe_d, d_oe_q, d_oe_d;
  logic          err_q, err_d, done_q, done_d;
  logic [IW-1:0] inh_q, inh_d;
  logic [TW-1:0] to_q, to_d;
  logic [3:0]    idx_q, idx_d;
  logic          c_sync, d_sync, fall, tmo;

  ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filt (
    .clk        (clk),
    .reset      (reset),
    .ps2c_i     (ps2c_in),
    .ps2d_i     (ps2d_in),
    .ps2c_sync_o(c_sync),
    .ps2d_sync_o(d_sync),
    .fall_o     (fall)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      par_q   <= 1'b0;
      c_oe_q  <= 1'b0;
      d_oe_q  <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      inh_q   <= '0;
      to_q    <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      par_q   <= par_d;
      c_oe_q  <= c_oe_d;
      d_oe_q  <= d_oe_d;
      err_q   <= err_d;
      done_q  <= done_d;
      inh_q   <= inh_d;
      to_q    <= to_d;
      idx_q   <= idx_d;
    end
  end

  assign tmo = (to_q == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    par_d   = par_q;
    c_oe_d  = c_oe_q;
    d_oe_d  = d_oe_q;
    err_d   = err_q;
    done_d  = 1'b0;
    inh_d   = inh_q;
    to_d    = to_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: if (wr) begin
        data_d  = din;
        par_d   = odd_parity(din);
        err_d   = 1'b0;
        c_oe_d  = 1'b1;
        inh_d   = '0;
        state_d = RTS;
      end
      RTS: begin
        inh_d = inh_q + 1'b1;
        // Start bit goes out one cycle before the clock is released.
        if (inh_q == IW'(INHIBIT_CYCLES - 2)) d_oe_d = 1'b1;
        if (inh_q == IW'(INHIBIT_CYCLES - 1)) begin
          c_oe_d  = 1'b0;
          idx_d   = '0;
          to_d    = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        to_d = to_q + 1'b1;
        if (fall) begin
          to_d  = '0;
          idx_d = idx_q + 4'd1;
          if (idx_q < 4'd8) d_oe_d = ~data_q[idx_q[2:0]];
          else if (idx_q == 4'd8) d_oe_d = ~par_q;
          else begin
            d_oe_d  = 1'b0;
            state_d = ACK;
          end
        end else if (tmo) begin
          {c_oe_d, d_oe_d} = 2'b00;
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      ACK: begin
        to_d = to_q + 1'b1;
        if (fall) begin
          to_d = '0;
          if (d_sync) err_d = 1'b1;
          state_d = WAIT_IDLE;
        end else if (tmo) begin
          {c_oe_d, d_oe_d} = 2'b00;
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      WAIT_IDLE: if (c_sync && d_sync) begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ps2c_oe   = c_oe_q;
  assign ps2d_oe   = d_oe_q;
  assign busy      = (state_q != IDLE);
  assign done_tick = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a table of full frames against a modelled
// keyboard, plus timeout-abort and mid-frame reset sequences.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH  = 100;
  localparam int TMO  = 2000;
  localparam int FL   = 8;
  localparam int HALF = 50;

  typedef struct {
    logic [7:0] din;
    bit         nack;
    bit         inj;
    bit         par;
    bit         err;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr = 1'b0;
  logic [7:0] din = 8'h00;
  logic       dev_clk = 1'b1, dev_dat = 1'b1;
  logic       ps2c_in, ps2d_in, ps2c_oe, ps2d_oe, busy, done_tick, err;
  int         n_cmp = 0, n_bad = 0, done_cnt = 0;
  vec_t       vecs[6];

  assign ps2c_in = dev_clk & ~ps2c_oe;
  assign ps2d_in = dev_dat & ~ps2d_oe;

  always #5 clk = ~clk;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .FILTER_LEN(FL)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr       (wr),
    .din      (din),
    .ps2c_in  (ps2c_in),
    .ps2d_in  (ps2d_in),
    .ps2c_oe  (ps2c_oe),
    .ps2d_oe  (ps2d_oe),
    .busy     (busy),
    .done_tick(done_tick),
    .err      (err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (done_tick) begin
      done_cnt++;
      chk("busy_low_at_done", 32'(busy), 32'd0);
    end
  end

  task automatic start_frame(input logic [7:0] b);
    int n;
    din = b; wr = 1'b1;
    tick();
    wr = 1'b0; din = 8'h00;
    chk("busy_after_wr", 32'(busy), 32'd1);
    chk("c_oe_after_wr", 32'(ps2c_oe), 32'd1);
    chk("err_cleared_on_wr", 32'(err), 32'd0);
    n = 0;
    while (ps2c_oe && n < INH + 50) begin
      n++;
      tick();
    end
    chk("inhibit_len_ok", 32'(n >= INH && n <= INH + 1), 32'd1);
    chk("start_bit", 32'(ps2d_oe), 32'd1);
  endtask

  // Keyboard model: generates nfalls clocks, samples the line at the end of each
  // low phase, optionally acks on clock 11 and optionally pokes wr mid-frame.
  task automatic dev_clock(input int nfalls, input bit nack, input bit inj,
                           output logic [9:0] bits);
    bits = '0;
    for (int i = 1; i <= nfalls; i++) begin
      if (i == 11 && !nack) dev_dat = 1'b0;
      dev_clk = 1'b0;
      if (inj && i == 3) begin
        din = 8'hFF; wr = 1'b1;
        tick();
        wr = 1'b0; din = 8'h00;
        tick(HALF - 1);
      end else begin
        tick(HALF);
      end
      if (i <= 10) bits[i-1] = ps2d_in;
      dev_clk = 1'b1;
      tick(HALF);
    end
    dev_dat = 1'b1;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done_cnt == 0 && n < 1000) begin
      tick();
      n++;
    end
    tick(3);
    chk("done_once", 32'(done_cnt), 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    logic [9:0] bits;
    done_cnt = 0;
    start_frame(v.din);
    tick(20);
    dev_clock(11, v.nack, v.inj, bits);
    wait_done();
    chk("data_byte", 32'(bits[7:0]), 32'(v.din));
    chk("parity_bit", 32'(bits[8]), 32'(v.par));
    chk("stop_bit", 32'(bits[9]), 32'd1);
    chk("err_end", 32'(err), 32'(v.err));
    chk("busy_end", 32'(busy), 32'd0);
    chk("oe_end", 32'({ps2c_oe, ps2d_oe}), 32'd0);
  endtask

  initial begin
    logic [9:0] bits;
    int k;
    bit seen;

    //             din    nack  inj   par   err
    vecs[0] = '{8'hED, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'h01, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{8'hED, 1'b1, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{8'hFF, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{8'hED, 1'b0, 1'b1, 1'b1, 1'b0};

    tick(3);
    chk("rst_c_oe", 32'(ps2c_oe), 32'd0);
    chk("rst_d_oe", 32'(ps2d_oe), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done_tick), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    reset = 1'b0;
    tick(5);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Device stalls after its 4th falling edge.
    done_cnt = 0;
    start_frame(8'h00);
    tick(20);
    dev_clock(3, 1'b0, 1'b0, bits);
    dev_clk = 1'b0;
    k = 0;
    seen = 1'b0;
    while (!seen && k < TMO + 200) begin
      tick();
      k++;
      if (k == HALF) begin
        chk("tmo_d_oe_held", 32'(ps2d_oe), 32'd1);
        dev_clk = 1'b1;
      end
      if (done_tick) seen = 1'b1;
    end
    chk("tmo_abort_seen", 32'(seen), 32'd1);
    chk("tmo_latency", 32'(k), 32'(TMO + FL + 3));
    chk("tmo_oe", 32'({ps2c_oe, ps2d_oe}), 32'd0);
    chk("tmo_err", 32'(err), 32'd1);
    chk("tmo_busy", 32'(busy), 32'd0);
    tick(5);

    // Reset lands right after the 5th falling edge.
    done_cnt = 0;
    start_frame(8'hED);
    tick(20);
    dev_clock(4, 1'b0, 1'b0, bits);
    dev_clk = 1'b0;
    tick(20);
    chk("pre_reset_d_oe", 32'(ps2d_oe), 32'd1);
    reset = 1'b1;
    tick();
    chk("reset_oe", 32'({ps2c_oe, ps2d_oe}), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_no_done", 32'(done_tick), 32'd0);
    tick();
    reset = 1'b0;
    dev_clk = 1'b1;
    tick(10);
    chk("reset_done_count", 32'(done_cnt), 32'd0);
    run_vec(vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
